// File: rtl/parity_arb_pkg.sv
// Shared types, default parameters and the parity rule for parity_check_arbiter.
package parity_arb_pkg;

  localparam int PARITY_ARB_N_REQ_DEF     = 4;
  localparam int PARITY_ARB_DATA_W_DEF    = 8;
  localparam int PARITY_ARB_ERR_CNT_W_DEF = 8;

  // Widest byte lane the parity helper accepts; callers zero-extend, which
  // leaves the XOR reduction unchanged.
  localparam int PARITY_ARB_MAX_DATA_W    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } parity_arb_state_e;

  // Even parity across data and parity bit: 1 means the byte arrived intact.
  function automatic logic parity_even_ok(
    input logic [PARITY_ARB_MAX_DATA_W-1:0] data,
    input logic                             parity
  );
    return ~(^data ^ parity);
  endfunction

endpackage

// File: rtl/parity_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module parity_rr_arbiter
  import parity_arb_pkg::*;
#(
  parameter  int N_REQ = PARITY_ARB_N_REQ_DEF,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             any
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IDW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (en && !any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one parity checker among N_REQ byte sources.
// Optional per-requester saturating parity-error counters are built only when
// the macro PARITY_ARB_ERR_CNT_EN is defined; otherwise err_cnt reads 0 and
// err_clr is ignored.
module parity_check_arbiter
  import parity_arb_pkg::*;
#(
  parameter  int N_REQ     = PARITY_ARB_N_REQ_DEF,
  parameter  int DATA_W    = PARITY_ARB_DATA_W_DEF,
  parameter  int ERR_CNT_W = PARITY_ARB_ERR_CNT_W_DEF,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_parity,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_ok,
  output logic                       busy,
  input  logic                       err_clr,
  output logic [N_REQ*ERR_CNT_W-1:0] err_cnt
);

  parity_arb_state_e state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_ok_q;

  // Capture registers hold the accepted byte across the CHECK cycle.
  logic [DATA_W-1:0] cap_data_q;
  logic              cap_par_q;
  logic [IDW-1:0]    cap_id_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDW-1:0]    arb_id;
  logic              arb_any;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_par;
  logic [IDW-1:0]    ptr_nxt;
  logic              check_ok;

  // Grant only in IDLE, so req_ready depends on req_valid and rr_ptr alone.
  parity_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (state_q == IDLE),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign req_ready = arb_gnt;

  // One-hot mux of the granted requester's byte and parity bit.
  always_comb begin
    gnt_data = '0;
    gnt_par  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        gnt_data = gnt_data | req_data[i*DATA_W +: DATA_W];
        gnt_par  = gnt_par | req_parity[i];
      end
    end
  end

  assign ptr_nxt  = (arb_id == IDW'(N_REQ - 1)) ? '0 : arb_id + IDW'(1);
  assign check_ok = parity_even_ok(PARITY_ARB_MAX_DATA_W'(cap_data_q), cap_par_q);

  // Accepted byte is latched on the handshake; contents are don't-care otherwise.
  always_ff @(posedge clk) begin
    if (arb_any) begin
      cap_data_q <= gnt_data;
      cap_par_q  <= gnt_par;
      cap_id_q   <= arb_id;
    end
  end

  // Control FSM: IDLE accepts, CHECK evaluates and loads the response, RESP holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ok_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            rr_ptr_q <= ptr_nxt;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          rsp_data_q  <= cap_data_q;
          rsp_id_q    <= cap_id_q;
          rsp_ok_q    <= check_ok;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ok    = rsp_ok_q;
  assign busy      = (state_q != IDLE);

`ifdef PARITY_ARB_ERR_CNT_EN
  logic [N_REQ-1:0][ERR_CNT_W-1:0] err_cnt_q;
  logic [N_REQ-1:0][ERR_CNT_W-1:0] err_cnt_d;

  // Clear has priority; a failed check bumps its requester's count, saturating.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (state_q == CHECK && !check_ok && err_cnt_q[cap_id_q] != '1) begin
      err_cnt_d[cap_id_q] = err_cnt_q[cap_id_q] + ERR_CNT_W'(1);
    end
  end

  // Counter state updates on the same edge that raises rsp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Scoreboard bench for parity_check_arbiter with a cycle-level reference model.
module tb_parity_check_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2;
`ifdef PARITY_ARB_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_parity = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ok;
  logic            busy;
  logic            err_clr = 1'b0;
  logic [N*CW-1:0] err_cnt;

  parity_check_arbiter #(.N_REQ(N), .DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_parity (req_parity),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ok     (rsp_ok),
    .busy       (busy),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int id;
    int data;
    bit ok;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   seen_ids[$];
  bit   last_ok;
  int   last_id;

  // Reference model state
  bit          pend[N];
  logic [DW-1:0] pdata[N];
  bit          ppar[N];
  int          m_state = 0;   // 0 idle, 1 check, 2 resp
  int          m_ptr = 0;
  int          m_cnt[N];
  int          infl_id = 0;
  bit          infl_ok = 1'b1;
  int          gen_pct = 0;
  int          rdy_mode = 1;  // 0 low, 1 high, 2 random
  int          clr_pct = 0;
  bit          clr_on_check = 1'b0;

  // Monitor state
  bit   mon_in_resp = 1'b0;
  bit   mon_have = 1'b0;
  exp_t mon_cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ok_of(input logic [DW-1:0] d, input bit p);
    return ((($countones(d) + int'(p)) % 2) == 0);
  endfunction

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= pend[i];
    return a;
  endfunction

  // One clock of stimulus plus model advance.
  task automatic step();
    int g;
    int best_d;
    int d;
    logic [N-1:0] exp_rdy;
    bit rdy_now;
    bit clr_now;
    @(negedge clk);
    chk("busy", busy, m_state != 0);
    chk("rsp_valid", rsp_valid, m_state == 2);
    for (int i = 0; i < N; i++)
      chk($sformatf("err_cnt%0d", i), err_cnt[i*CW +: CW], CNT_EN ? m_cnt[i] : 0);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < gen_pct)) begin
        pend[i]  = 1'b1;
        pdata[i] = DW'($urandom);
        ppar[i]  = 1'($urandom_range(1));
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_data[i*DW +: DW]   = pend[i] ? pdata[i] : DW'($urandom);
      req_parity[i]          = pend[i] ? ppar[i] : 1'($urandom_range(1));
    end
    rdy_now   = (rdy_mode == 2) ? ($urandom_range(99) < 70) : (rdy_mode == 1);
    clr_now   = ($urandom_range(99) < clr_pct) || (clr_on_check && m_state == 1);
    rsp_ready = rdy_now;
    err_clr   = clr_now;
    #1;
    g = -1;
    best_d = N;
    if (m_state == 0) begin
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (pend[i] && d < best_d) begin
          best_d = d;
          g = i;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (clr_now) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_state == 1 && !infl_ok && m_cnt[infl_id] < (1 << CW) - 1) begin
      m_cnt[infl_id]++;
    end
    case (m_state)
      0: if (g >= 0) begin
        sbq.push_back('{id: g, data: int'(pdata[g]), ok: ok_of(pdata[g], ppar[g]), acc: cyc});
        infl_id = g;
        infl_ok = ok_of(pdata[g], ppar[g]);
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % N;
        m_state = 1;
      end
      1: m_state = 2;
      default: if (rdy_now) m_state = 0;
    endcase
  endtask

  task automatic drain(input string nm);
    int n = 0;
    gen_pct  = 0;
    rdy_mode = 1;
    clr_pct  = 0;
    while ((any_pend() || m_state != 0 || sbq.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_drain_in_budget"}, (n < 300), 1);
  endtask

  task automatic send(input int id, input logic [DW-1:0] d, input bit p);
    pend[id]  = 1'b1;
    pdata[id] = d;
    ppar[id]  = p;
    drain("send");
  endtask

  task automatic pulse_clr();
    clr_pct = 100;
    step();
    clr_pct = 0;
  endtask

  // Response monitor: pops the scoreboard on each new response and checks it is held.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mon_in_resp = 1'b0;
        mon_have    = 1'b0;
      end else if (rsp_valid) begin
        if (!mon_in_resp) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            mon_have = 1'b0;
            $display("FAIL spurious_rsp: got response id %0d, required none", rsp_id);
          end else begin
            mon_cur  = sbq.pop_front();
            mon_have = 1'b1;
            chk("latency", 64'(cyc - mon_cur.acc), 2);
            seen_ids.push_back(int'(rsp_id));
            last_ok = rsp_ok;
            last_id = int'(rsp_id);
          end
        end
        if (mon_have) begin
          chk("rsp_id", rsp_id, mon_cur.id);
          chk("rsp_data", rsp_data, mon_cur.data);
          chk("rsp_ok", rsp_ok, mon_cur.ok);
        end
        mon_in_resp = 1'b1;
      end else begin
        mon_in_resp = 1'b0;
        mon_have    = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion, required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_values(input string nm);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_rsp_ok"}, rsp_ok, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err_cnt"}, err_cnt, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    int ord[6];
    int n;
    ord = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
      ppar[i]  = 1'b0;
      m_cnt[i] = 0;
    end

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters held busy: strict rotation from pointer 0.
    seen_ids.delete();
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      pdata[i] = DW'($urandom);
      ppar[i]  = 1'($urandom_range(1));
    end
    gen_pct  = 100;
    rdy_mode = 1;
    repeat (18) step();
    drain("rotation");
    for (int i = 0; i < 6; i++)
      chk($sformatf("grant_order%0d", i), (i < seen_ids.size()) ? seen_ids[i] : -1, ord[i]);

    pulse_clr();

    // Single good byte on requester 0.
    send(0, 8'hA5, 1'b0);
    chk("a5_ok", last_ok, 1);
    chk("a5_id", last_id, 0);

    // Bad then good byte on requester 2.
    send(2, 8'h01, 1'b0);
    chk("bad_ok", last_ok, 0);
    chk("bad_cnt2", err_cnt[2*CW +: CW], CNT_EN ? 1 : 0);
    send(2, 8'h01, 1'b1);
    chk("good_ok", last_ok, 1);
    chk("cnt2_unchanged", err_cnt[2*CW +: CW], CNT_EN ? 1 : 0);

    // Consumer stalls in RESP for 5 cycles while another request waits.
    pend[1]  = 1'b1;
    pdata[1] = 8'h3C;
    ppar[1]  = 1'b0;
    rdy_mode = 0;
    n = 0;
    while (m_state != 2 && n < 20) begin
      step();
      n++;
    end
    pend[3]  = 1'b1;
    pdata[3] = 8'hC3;
    ppar[3]  = 1'b1;
    repeat (5) step();
    chk("hold_busy", busy, 1);
    chk("hold_req_ready", req_ready, 0);
    chk("hold_rsp_valid", rsp_valid, 1);
    drain("hold");

    // Saturation at all-ones and clear winning over a same-cycle increment.
    pulse_clr();
    repeat (4) send(1, 8'h01, 1'b0);
    chk("sat_cnt1", err_cnt[1*CW +: CW], CNT_EN ? 3 : 0);
    clr_on_check = 1'b1;
    send(1, 8'h01, 1'b0);
    clr_on_check = 1'b0;
    chk("clr_wins", err_cnt[1*CW +: CW], 0);

    // Random traffic with random back-pressure and occasional clears.
    gen_pct  = 40;
    rdy_mode = 2;
    clr_pct  = 5;
    repeat (400) step();
    drain("random");

    // Reset asserted while a byte sits in CHECK.
    pend[2]  = 1'b1;
    pdata[2] = 8'h77;
    ppar[2]  = 1'b1;
    rdy_mode = 1;
    n = 0;
    while (m_state != 1 && n < 20) begin
      step();
      n++;
    end
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    err_clr   = 1'b0;
    #1;
    check_reset_values("midrst");
    m_state = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      pend[i]  = 1'b0;
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(3, 8'h5A, 1'b0);
    chk("post_rst_id", last_id, 3);
    chk("post_rst_ok", last_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_check_arbiter.md
# parity_check_arbiter

Shares one parity-check datapath among `N_REQ` byte requesters using round-robin arbitration and valid/ready handshakes. It sits between producer ports (UART/bus byte sources) and a single downstream consumer. For each accepted byte it returns the data, the requester id and a parity-ok flag. It optionally keeps per-requester parity-error counters.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2
- `DATA_W`, 8: data width
- `ERR_CNT_W`, 8: width of each error counter

Ports:
- `clk`  in  1  : single clock, rising edge
- `rst_n`  in  1  : asynchronous, active-low reset
- `req_valid`  in  N_REQ  : per-requester byte valid
- `req_data`  in  N_REQ*DATA_W  : requester i occupies bits [i*DATA_W +: DATA_W]
- `req_parity`  in  N_REQ  : per-requester parity bit
- `req_ready`  out  N_REQ  : one-hot grant/accept
- `rsp_valid`  out  1  : response valid
- `rsp_ready`  in  1  : consumer accepts response
- `rsp_id`  out  $clog2(N_REQ)  : requester index
- `rsp_data`  out  DATA_W  : checked byte
- `rsp_ok`  out  1  : 1 = parity correct
- `busy`  out  1  : state ≠ IDLE
- `err_clr`  in  1  : synchronous clear of all error counters
- `err_cnt`  out  N_REQ*ERR_CNT_W  : per-requester saturating error counts

## Operation
- The parity rule is even parity over data plus parity bit: `ok = ~(^data ^ parity)`.
- FSM states: IDLE, CHECK, RESP.
- **IDLE:**
  - Grant goes to the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready` is combinational, one-hot on the grant, and zero when no request is valid.
  - On handshake: capture data, parity and id; set `rr_ptr` to (id+1) mod N_REQ; go to CHECK.
- **CHECK:**
  - Load `rsp_data`, `rsp_id` and `rsp_ok`.
  - Set `rsp_valid`=1.
  - Increment the error counter when ok=0.
  - Go to RESP.
- **RESP:**
  - Response outputs hold stable while `rsp_valid`=1.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in CHECK and RESP. Requesters hold valid/data/parity stable until accepted.
- Non-granted requesters are not starved. Each waits at most N_REQ-1 grants.
- Error counters:
  - Saturate at all-ones.
  - `err_clr` wins over a same-cycle increment; the result is 0.
- Reset values: state IDLE, `rr_ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `rsp_ok` 0, `busy` 0, all `err_cnt` 0. `req_ready` is 0 until a valid request arrives.
- Reset mid-transaction: the byte is dropped, no response is produced, and counters are cleared.

## Timing
- Request accepted at edge t → CHECK during cycle t+1 → `rsp_valid` high from edge t+2.
- Latency is 2 cycles from accept to response.
- Best-case throughput is one transaction per 3 cycles, when `rsp_ready` is held high.
- The counter update is visible on `err_cnt` from the same edge that raises `rsp_valid`.
- `req_ready` depends combinationally on `req_valid` and `rr_ptr` only. There is no path from `rsp_ready` to `req_ready`.
- `rsp_*` outputs are registered.

## Configuration
- `PARITY_ARB_ERR_CNT_EN` defined: error counters and `err_clr` are active as described.
- Macro undefined:
  - Counters are not instantiated.
  - `err_cnt` is tied to 0.
  - `err_clr` is ignored.
  - All other behaviour is identical.

## Structure
- Package `parity_arb_pkg` holds:
  - the state enum `parity_arb_state_e` (IDLE, CHECK, RESP);
  - default parameter constants;
  - the function `parity_even_ok(data, parity)`.
- Sub-module `parity_rr_arbiter(N_REQ)`:
  - inputs: `req`, `ptr`, `en`;
  - outputs: one-hot `gnt`, `gnt_id`, `any`.
  - It is purely combinational. `rr_ptr` stays in the top module.
- The top module owns the FSM, capture registers and counters.

## Test plan
- Requester 0, data 8'hA5, parity 0 → `req_ready[0]`=1 same cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8'hA5, `rsp_ok`=1.
- Requester 2, data 8'h01, parity 0 → `rsp_ok`=0 and `err_cnt[2]`=1. Retest with parity 1 → `rsp_ok`=1, count unchanged.
- All four `req_valid` held high with `rsp_ready`=1 → grant order 0,1,2,3,0,1; one response every 3 cycles.
- Hold `rsp_ready` low for 5 cycles in RESP → `rsp_*` stable, `req_ready` all 0, `busy`=1; the release cycle returns to IDLE.
- Build with ERR_CNT_W=2 and send 4 bad bytes on requester 1 → `err_cnt[1]`=3. Assert `err_clr` in the same cycle as a 5th error → 0. Build without `PARITY_ARB_ERR_CNT_EN` → `err_cnt` stays 0.
- Assert `rst_n` low during CHECK → all outputs at reset values, no response emitted. After release, requester 3 alone is granted with id 3.
